serial_subtractor: RTL
======================

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 The module SHALL have parameter N, default 8, giving the operand width in bits; legal range is N >= 2.
REQ-002 The module SHALL have port input_clock, input, 1 bit, the single clock; all state is updated on its rising edge.
REQ-003 The module SHALL have port input_reset, input, 1 bit, an asynchronous active-high reset.
REQ-004 The module SHALL have port input_start, input, 1 bit, a request to begin a subtraction.
REQ-005 The module SHALL have port input_a, input, N bits, the minuend.
REQ-006 The module SHALL have port input_b, input, N bits, the subtrahend.
REQ-007 The module SHALL have port input_borrow, input, 1 bit, the borrow-in.
REQ-008 The module SHALL have port output_difference, output, N bits, the registered result of A - B - borrow_in, modulo 2^N.
REQ-009 The module SHALL have port output_borrow, output, 1 bit, the registered borrow out of the MSB.
REQ-010 The module SHALL have port output_overflow, output, 1 bit, the registered two's-complement signed overflow flag.
REQ-011 The module SHALL have port output_busy, output, 1 bit, which is high while a subtraction is in progress.
REQ-012 The module SHALL have port output_done, output, 1 bit, a one-cycle completion pulse.

Function
REQ-013 The module SHALL implement a three-state machine with states IDLE, RUN and DONE.
REQ-014 In IDLE, when input_start is sampled high on a rising edge, the module SHALL capture input_a, input_b and input_borrow into internal registers, clear the bit counter to 0, and enter RUN.
REQ-015 The module SHALL ignore input_start in RUN and DONE; a start request in those states SHALL be neither queued nor allowed to alter the operands.
REQ-016 In RUN, on each rising edge, the module SHALL process bit i = counter, LSB first, as follows:
- d_i = a_i ^ b_i ^ br
- br_next = (~a_i & b_i) | (~(a_i ^ b_i) & br)
- store d_i into bit i of an internal shift/result register
- increment the counter.
REQ-017 On the edge that processes bit N-1, the module SHALL:
- load output_difference from the internal result;
- set output_borrow = br_next;
- set output_overflow = (borrow into bit N-1) XOR (borrow out of bit N-1);
- enter DONE.
REQ-018 Latency: with start sampled at edge 0, output_busy SHALL be high from edge 0 until edge N, and output_done SHALL be high for exactly the one cycle between edge N and edge N+1.
REQ-019 DONE SHALL return unconditionally to IDLE on the next edge, so the earliest accepted restart is at edge N+1.
REQ-020 Outputs output_difference, output_borrow and output_overflow SHALL change only at completion and SHALL hold their values until the next completion.
REQ-021 Operand inputs SHALL be don't-care after capture; changing them during RUN SHALL NOT affect the result.
REQ-022 The counter SHALL be exactly wide enough to count 0..N-1; no wrap beyond N-1 SHALL occur.

Reset
REQ-023 Asserting input_reset SHALL immediately, without waiting for a clock edge:
- force state to IDLE;
- clear the counter, operand registers and internal borrow;
- drive output_difference = 0, output_borrow = 0, output_overflow = 0, output_busy = 0 and output_done = 0.
REQ-024 A reset during RUN SHALL abort the operation, SHALL produce no output_done pulse, and SHALL leave the previous result cleared to 0.
REQ-025 While input_reset is high, input_start SHALL be ignored; the first start accepted is on the first rising edge after deassertion.

Verification (N=8)
REQ-026 The bench SHALL apply a=0x05, b=0x03, borrow_in=0 -> difference 0x02, borrow 0, overflow 0, with done exactly 8 edges after the start edge and busy high for 8 cycles.
REQ-027 The bench SHALL apply a=0x00, b=0x01, borrow_in=0 -> difference 0xFF, borrow 1, overflow 0.
REQ-028 The bench SHALL apply a=0x80, b=0x01, borrow_in=0 -> difference 0x7F, borrow 0, overflow 1; it SHALL also apply a=0x7F, b=0xFF -> difference 0x80, borrow 1, overflow 1.
REQ-029 The bench SHALL apply a=0x10, b=0x0F, borrow_in=1 -> difference 0x00, borrow 0, overflow 0.
REQ-030 The bench SHALL start a=0x20, b=0x01, then pulse start with a=0xFF, b=0xFF at cycle 3 and change the operands mid-RUN -> result 0x1F, and only one done pulse is produced.
REQ-031 The bench SHALL assert reset asynchronously (between clock edges) at cycle 4 of RUN -> busy falls immediately, all outputs are 0, no done pulse occurs, and a following start with a=0x09, b=0x04 gives 0x05.

Source files
------------

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes A - B - borrow_in one bit per clock, LSB first,
// and presents registered difference, borrow and signed-overflow flags at completion.
module serial_subtractor #(
  parameter int N = 8
) (
  input  logic         input_clock,
  input  logic         input_reset,
  input  logic         input_start,
  input  logic [N-1:0] input_a,
  input  logic [N-1:0] input_b,
  input  logic         input_borrow,
  output logic [N-1:0] output_difference,
  output logic         output_borrow,
  output logic         output_overflow,
  output logic         output_busy,
  output logic         output_done
);

  localparam int CW = $clog2(N);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [CW-1:0] count;
  logic [N-1:0]  a_reg;
  logic [N-1:0]  b_reg;
  logic [N-1:0]  result;
  logic          br;

  logic a_bit;
  logic b_bit;
  logic d_bit;
  logic br_next;
  logic last_bit;

  // NOTE: every signal written here gets a value before any branch, so no latch is inferred.
  always_comb begin
    a_bit      = a_reg[count];
    b_bit      = b_reg[count];
    d_bit      = a_bit ^ b_bit ^ br;
    br_next    = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & br);
    last_bit   = (count == CW'(N - 1));
    state_next = state;
    case (state)
      IDLE:    if (input_start) state_next = RUN;
      RUN:     if (last_bit) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign output_busy = (state == RUN);
  assign output_done = (state == DONE);

  // NOTE: state is updated with non-blocking assignments so every register samples
  // pre-edge values. The result register is small and flop-based, so it is reset
  // along with everything else; an aborted run leaves no stale partial bits behind.
  always_ff @(posedge input_clock or posedge input_reset) begin
    if (input_reset) begin
      state             <= IDLE;
      count             <= '0;
      a_reg             <= '0;
      b_reg             <= '0;
      br                <= 1'b0;
      result            <= '0;
      output_difference <= '0;
      output_borrow     <= 1'b0;
      output_overflow   <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (input_start) begin
            a_reg <= input_a;
            b_reg <= input_b;
            br    <= input_borrow;
            count <= '0;
          end
        end
        RUN: begin
          result[count] <= d_bit;
          br            <= br_next;
          if (last_bit) begin
            // The MSB is still being computed this edge, so merge it in directly.
            output_difference <= {d_bit, result[N-2:0]};
            output_borrow     <= br_next;
            output_overflow   <= br ^ br_next;
          end else begin
            count <= count + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
